clip_tri_emitter: RTL and testbench

CLIP_TRI_EMITTER -- requirements
Module: clip_tri_emitter

---
 rtl/clip_tri_emitter.sv | 182 ++++++++++++++++++
 tb/tb_clip_tri_emitter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_tri_emitter.sv
// Sequences one clip job: starts the clipper, captures its result, and emits
// up to two triangles downstream with valid/ready handshaking and counters.
module clip_tri_emitter #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                reset_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic                busy_o,
    output logic                clip_start_o,
    input  logic                clip_done_i,
    input  logic                clip_valid_i,
    input  logic [1:0]          clip_num_tri_i,
    input  logic [24*WIDTH-1:0] clip_verts_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [12*WIDTH-1:0] out_tri_o,
    output logic                out_last_o,
    output logic [15:0]         tri_count_o,
    output logic [15:0]         cull_count_o,
    output logic                error_o
);
    localparam int TRI_W = 12 * WIDTH;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DONE,
        ST_RELEASE,
        ST_EMIT0,
        ST_EMIT1
    } state_t;

    state_t              state_q, state_d;
    logic                clip_start_q, clip_start_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [2*TRI_W-1:0]  cap_verts_q, cap_verts_d;
    logic [1:0]          cap_num_q, cap_num_d;
    logic                cap_valid_q, cap_valid_d;
    logic                discard_q, discard_d;
    logic                out_valid_q, out_valid_d;
    logic [TRI_W-1:0]    out_tri_q, out_tri_d;
    logic                out_last_q, out_last_d;
    logic [15:0]         tri_count_q, tri_count_d;
    logic [15:0]         cull_count_q, cull_count_d;
    logic                error_q, error_d;
    logic [1:0]          eff_num;

    // A reported count of 3 cannot be represented by two vertex slots; emit one.
    assign eff_num = (cap_num_q == 2'd3) ? 2'd1 : cap_num_q;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        clip_start_d = clip_start_q;
        tmo_cnt_d    = tmo_cnt_q;
        cap_verts_d  = cap_verts_q;
        cap_num_d    = cap_num_q;
        cap_valid_d  = cap_valid_q;
        discard_d    = discard_q;
        out_valid_d  = out_valid_q;
        out_tri_d    = out_tri_q;
        out_last_d   = out_last_q;
        tri_count_d  = tri_count_q;
        cull_count_d = cull_count_q;
        error_d      = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d      = ST_WAIT_DONE;
                    clip_start_d = 1'b1;
                    tmo_cnt_d    = '0;
                end
            end
            ST_WAIT_DONE: begin
                if (clip_done_i) begin
                    cap_verts_d  = clip_verts_i;
                    cap_num_d    = clip_num_tri_i;
                    cap_valid_d  = clip_valid_i;
                    discard_d    = 1'b0;
                    clip_start_d = 1'b0;
                    state_d      = ST_RELEASE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    error_d      = 1'b1;
                    discard_d    = 1'b1;
                    clip_start_d = 1'b0;
                    state_d      = ST_RELEASE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Wait for done to drop so the clipper is idle before the next start.
                if (!clip_done_i) begin
                    if (discard_q) begin
                        state_d = ST_IDLE;
                    end else if (!cap_valid_q || cap_num_q == 2'd0) begin
                        state_d = ST_IDLE;
                        if (cull_count_q != 16'hFFFF) cull_count_d = cull_count_q + 16'd1;
                    end else begin
                        state_d     = ST_EMIT0;
                        out_valid_d = 1'b1;
                        out_tri_d   = cap_verts_q[TRI_W-1:0];
                        out_last_d  = (eff_num == 2'd1);
                    end
                end
            end
            ST_EMIT0: begin
                if (out_ready_i) begin
                    tri_count_d = tri_count_q + 16'd1;
                    if (eff_num == 2'd2) begin
                        state_d    = ST_EMIT1;
                        out_tri_d  = cap_verts_q[2*TRI_W-1:TRI_W];
                        out_last_d = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            ST_EMIT1: begin
                if (out_ready_i) begin
                    tri_count_d = tri_count_q + 16'd1;
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            clip_start_q <= 1'b0;
            tmo_cnt_q    <= '0;
            // NOTE: capture registers are reset as well so a reset leaves no stale job data.
            cap_verts_q  <= '0;
            cap_num_q    <= '0;
            cap_valid_q  <= 1'b0;
            discard_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tri_q    <= '0;
            out_last_q   <= 1'b0;
            tri_count_q  <= '0;
            cull_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together from pre-edge values.
            state_q      <= state_d;
            clip_start_q <= clip_start_d;
            tmo_cnt_q    <= tmo_cnt_d;
            cap_verts_q  <= cap_verts_d;
            cap_num_q    <= cap_num_d;
            cap_valid_q  <= cap_valid_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            out_tri_q    <= out_tri_d;
            out_last_q   <= out_last_d;
            tri_count_q  <= tri_count_d;
            cull_count_q <= cull_count_d;
            error_q      <= error_d;
        end
    end

    assign in_ready_o   = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign clip_start_o = clip_start_q;
    assign out_valid_o  = out_valid_q;
    assign out_tri_o    = out_tri_q;
    assign out_last_o   = out_last_q;
    assign tri_count_o  = tri_count_q;
    assign cull_count_o = cull_count_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_clip_tri_emitter.sv
// Self-checking bench for clip_tri_emitter: directed job table, hand-written
// reset/timeout sequences, and randomized jobs against a job-level model.
module tb_clip_tri_emitter;
    localparam int W     = 24;
    localparam int TRI_W = 12 * W;
    localparam int TMO   = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              busy_o;
    logic              clip_start_o;
    logic              clip_done_i;
    logic              clip_valid_i;
    logic [1:0]        clip_num_tri_i;
    logic [24*W-1:0]   clip_verts_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [TRI_W-1:0]  out_tri_o;
    logic              out_last_o;
    logic [15:0]       tri_count_o;
    logic [15:0]       cull_count_o;
    logic              error_o;

    clip_tri_emitter dut (
        .clk_i         (clk),
        .reset_n       (reset_n),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .busy_o        (busy_o),
        .clip_start_o  (clip_start_o),
        .clip_done_i   (clip_done_i),
        .clip_valid_i  (clip_valid_i),
        .clip_num_tri_i(clip_num_tri_i),
        .clip_verts_i  (clip_verts_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_tri_o     (out_tri_o),
        .out_last_o    (out_last_o),
        .tri_count_o   (tri_count_o),
        .cull_count_o  (cull_count_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Job-level model state
    int unsigned exp_tri  = 0;
    int unsigned exp_cull = 0;
    bit          exp_err  = 1'b0;

    typedef struct {
        int     dly;
        bit     vld;
        bit [1:0] num;
        int     stall;
        int     hold;
        bit     tmo;
        int     exp_n;
    } vec_t;

    task automatic check(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [24*W-1:0] rand_verts();
        logic [24*W-1:0] r;
        for (int i = 0; i < 18; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Triangles a job should produce, straight from the job rules.
    function automatic int model_tris(input bit vld, input bit [1:0] num, input bit tmo);
        if (tmo || !vld || num == 2'd0) return 0;
        return (num == 2'd3) ? 1 : int'(num);
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", in_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_start", clip_start_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_last", out_last_o, 0);
        check("rst_out_tri", out_tri_o, 0);
        check("rst_tri_count", tri_count_o, 0);
        check("rst_cull_count", cull_count_o, 0);
        check("rst_error", error_o, 0);
        reset_n  = 1'b1;
        exp_tri  = 0;
        exp_cull = 0;
        exp_err  = 1'b0;
        tick();
    endtask

    task automatic run_job(input vec_t j);
        logic [24*W-1:0]  v;
        logic [TRI_W-1:0] want;
        check("idle_ready", in_ready_o, 1);
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("start_latency", clip_start_o, 1);
        check("busy_hi", busy_o, 1);
        if (j.tmo) begin
            repeat (TMO - 1) tick();
            check("tmo_start_held", clip_start_o, 1);
            check("tmo_err_early", error_o, exp_err);
            tick();
            exp_err = 1'b1;
            check("tmo_start_low", clip_start_o, 0);
            check("tmo_err_set", error_o, 1);
            tick();
        end else begin
            repeat (j.dly) tick();
            v              = rand_verts();
            clip_verts_i   = v;
            clip_valid_i   = j.vld;
            clip_num_tri_i = j.num;
            clip_done_i    = 1'b1;
            tick();
            check("start_low", clip_start_o, 0);
            check("no_out_at_done", out_valid_o, 0);
            for (int h = 0; h < j.hold; h++) begin
                tick();
                check("hold_no_out", out_valid_o, 0);
                check("hold_busy", busy_o, 1);
            end
            clip_done_i    = 1'b0;
            clip_verts_i   = ~v;
            clip_valid_i   = ~j.vld;
            clip_num_tri_i = ~j.num;
            tick();
            if (j.exp_n == 0 && exp_cull < 65535) exp_cull++;
            for (int t = 0; t < j.exp_n; t++) begin
                want = (t == 0) ? v[TRI_W-1:0] : v[2*TRI_W-1:TRI_W];
                for (int s = 0; s < j.stall; s++) begin
                    check("stall_valid", out_valid_o, 1);
                    check("stall_tri", out_tri_o, want);
                    check("stall_last", out_last_o, (t == j.exp_n - 1));
                    tick();
                end
                check("out_valid", out_valid_o, 1);
                check("out_tri", out_tri_o, want);
                check("out_last", out_last_o, (t == j.exp_n - 1));
                out_ready_i = 1'b1;
                tick();
                out_ready_i = 1'b0;
                exp_tri = (exp_tri + 1) % 65536;
            end
        end
        check("end_ready", in_ready_o, 1);
        check("end_no_valid", out_valid_o, 0);
        check("tri_count", tri_count_o, exp_tri);
        check("cull_count", cull_count_o, exp_cull);
        check("error", error_o, exp_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        vec_t r;
        logic [24*W-1:0] v;

        reset_n        = 1'b0;
        in_valid_i     = 1'b0;
        clip_done_i    = 1'b0;
        clip_valid_i   = 1'b0;
        clip_num_tri_i = 2'd0;
        clip_verts_i   = '0;
        out_ready_i    = 1'b0;

        //            dly vld num stall hold tmo exp_n
        vecs[0]  = '{5,  1, 1, 0, 0, 0, 1};   // pass-through
        vecs[1]  = '{3,  1, 2, 3, 0, 0, 2};   // quad split, backpressure
        vecs[2]  = '{2,  0, 0, 0, 0, 0, 0};   // cull
        vecs[3]  = '{1,  0, 2, 0, 0, 0, 0};   // invalid with count
        vecs[4]  = '{0,  1, 0, 0, 0, 0, 0};   // valid, zero count
        vecs[5]  = '{4,  1, 3, 1, 0, 0, 1};   // count 3 -> 1
        vecs[6]  = '{2,  1, 2, 0, 4, 0, 2};   // done held 4 cycles
        vecs[7]  = '{63, 1, 1, 0, 0, 0, 1};   // done on terminal count wins
        vecs[8]  = '{0,  1, 2, 1, 1, 0, 2};   // immediate done
        vecs[9]  = '{0,  1, 1, 0, 0, 1, 0};   // timeout
        vecs[10] = '{5,  1, 2, 2, 0, 0, 2};   // normal job after timeout

        do_reset();
        for (int i = 0; i < 11; i++) run_job(vecs[i]);

        // Reset while stalled in the second triangle
        in_valid_i = 1'b1;
        tick();
        in_valid_i     = 1'b0;
        v              = rand_verts();
        clip_verts_i   = v;
        clip_valid_i   = 1'b1;
        clip_num_tri_i = 2'd2;
        clip_done_i    = 1'b1;
        tick();
        clip_done_i = 1'b0;
        tick();
        check("e0_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("e1_valid", out_valid_o, 1);
        check("e1_tri", out_tri_o, v[2*TRI_W-1:TRI_W]);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid_o, 0);
        check("async_rst_tri_count", tri_count_o, 0);
        check("async_rst_ready", in_ready_o, 1);
        check("async_rst_error", error_o, 0);
        tick();
        reset_n  = 1'b1;
        exp_tri  = 0;
        exp_cull = 0;
        exp_err  = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_no_emit", out_valid_o, 0);
        end
        out_ready_i = 1'b0;
        check("post_rst_tri_count", tri_count_o, 0);

        // Randomized jobs against the model
        for (int j = 0; j < 40; j++) begin
            r.tmo   = ($urandom_range(0, 9) == 0);
            r.dly   = ($urandom_range(0, 7) == 0) ? 63 : int'($urandom_range(0, 8));
            r.vld   = ($urandom_range(0, 3) != 0);
            r.num   = 2'($urandom_range(0, 3));
            r.stall = int'($urandom_range(0, 3));
            r.hold  = int'($urandom_range(0, 3));
            r.exp_n = model_tris(r.vld, r.num, r.tmo);
            run_job(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
